// File: rtl/fp_mul_seq_if.sv
// Operand/result handshake bundle for the sequential floating-point multiplier.
interface fp_mul_seq_if #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;
    logic [3:0]   out_flags;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_result, out_flags
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_result, out_flags
    );
endinterface

// File: rtl/fp_mul_seq.sv
// Sequential IEEE-754-style multiplier: radix-4 Booth significand engine,
// round-to-nearest-even, flush-to-zero, flags {invalid, overflow, underflow, inexact}.
module fp_mul_seq #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    fp_mul_seq_if.slave bus
);
    localparam int W   = 1 + EXP_W + MAN_W;
    localparam int SW  = MAN_W + 1;          // significand with implicit bit
    localparam int BW  = MAN_W + 3;          // Booth multiplier register
    localparam int N   = (MAN_W + 3) / 2;    // Booth digits
    localparam int AW  = 2 * MAN_W + 4;      // signed accumulator
    localparam int PW  = 2 * MAN_W + 2;      // unsigned product
    localparam int EW  = EXP_W + 2;          // signed working exponent
    localparam int CW  = $clog2(N + 1);
    localparam int LZW = $clog2(PW + 1);

    localparam logic signed [EW-1:0] BIAS  = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW-1:0] E_MAX = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] E_ONE = EW'(1);
    localparam logic signed [EW-1:0] E_ZRO = '0;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_RND  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]           state;
    logic                 out_valid_r;
    logic [W-1:0]         res_r;
    logic [3:0]           flags_r;
    logic signed [AW-1:0] acc;
    logic [SW-1:0]        mcand;
    logic [BW-1:0]        mq;
    logic                 qm1;
    logic [CW-1:0]        cnt;
    logic signed [EW-1:0] e_reg;
    logic                 sign_r;

    // operand field split and classification
    logic               sa, sb, sgn;
    logic [EXP_W-1:0]   ea, eb;
    logic [MAN_W-1:0]   fa, fb;
    logic               ezero_a, ezero_b, nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
    logic [SW-1:0]      sig_a, sig_b;
    logic signed [EW-1:0] eeff_a, eeff_b, e_sum;

    assign {sa, ea, fa} = bus.in_a;
    assign {sb, eb, fb} = bus.in_b;
    assign sgn     = sa ^ sb;
    assign ezero_a = ~|ea;
    assign ezero_b = ~|eb;
    assign nan_a   = (&ea) & (|fa);
    assign nan_b   = (&eb) & (|fb);
    assign inf_a   = (&ea) & ~(|fa);
    assign inf_b   = (&eb) & ~(|fb);
    assign zero_a  = ezero_a & ~(|fa);
    assign zero_b  = ezero_b & ~(|fb);
    assign sig_a   = {~ezero_a, fa};
    assign sig_b   = {~ezero_b, fb};
    assign eeff_a  = ezero_a ? E_ONE : EW'(ea);
    assign eeff_b  = ezero_b ? E_ONE : EW'(eb);
    assign e_sum   = eeff_a + eeff_b - BIAS;

    logic         special;
    logic [W-1:0] spec_res;
    logic [3:0]   spec_flags;

    // special-operand results bypass the multiplier entirely
    always_comb begin
        special    = 1'b1;
        spec_res   = '0;
        spec_flags = 4'b0000;
        if (nan_a | nan_b | (inf_a & zero_b) | (inf_b & zero_a)) begin
            spec_res   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            spec_flags = 4'b1000;
        end else if (inf_a | inf_b) begin
            spec_res = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (zero_a | zero_b) begin
            spec_res = {sgn, {(W-1){1'b0}}};
        end else begin
            special = 1'b0;
        end
    end

    // Booth partial product aligned at the top of the accumulator
    logic signed [AW+1:0] m1, m2, pp, acc_ext, sum;
    assign m1      = (AW+2)'(mcand) << (2 * N);
    assign m2      = m1 <<< 1;
    assign acc_ext = {{2{acc[AW-1]}}, acc};
    assign sum     = acc_ext + pp;

    // select the digit from the current multiplier triplet
    always_comb begin
        pp = '0;
        case ({mq[1:0], qm1})
            3'b001, 3'b010: pp = m1;
            3'b011:         pp = m2;
            3'b100:         pp = -m2;
            3'b101, 3'b110: pp = -m1;
            default:        pp = '0;
        endcase
    end

    logic [PW-1:0]  prod, norm;
    logic [LZW-1:0] lz;
    assign prod = acc[PW-1:0];

    // leading-zero count of the product (highest set bit wins)
    always_comb begin
        lz = '0;
        for (int i = 0; i < PW; i++) begin
            if (prod[i]) lz = LZW'(PW - 1 - i);
        end
    end

    logic                 guard, sticky, rup, carry;
    logic [MAN_W+1:0]     rsig;
    logic [MAN_W-1:0]     frac_r;
    logic signed [EW-1:0] lz_s, e_r;

    // normalise, round to nearest even, renormalise on carry
    always_comb begin
        norm   = prod << lz;
        guard  = norm[PW-2-MAN_W];
        sticky = |norm[PW-3-MAN_W:0];
        rup    = guard & (sticky | norm[PW-1-MAN_W]);
        rsig   = {1'b0, norm[PW-1 -: SW]} + (MAN_W+2)'(rup);
        carry  = rsig[MAN_W+1];
        frac_r = carry ? rsig[MAN_W:1] : rsig[MAN_W-1:0];
        lz_s   = EW'(lz);
        e_r    = e_reg + E_ONE - lz_s + (carry ? E_ONE : E_ZRO);
    end

    // control FSM and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            out_valid_r <= 1'b0;
            res_r       <= '0;
            flags_r     <= 4'b0000;
            acc         <= '0;
            mcand       <= '0;
            mq          <= '0;
            qm1         <= 1'b0;
            cnt         <= '0;
            e_reg       <= '0;
            sign_r      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        sign_r <= sgn;
                        if (special) begin
                            res_r   <= spec_res;
                            flags_r <= spec_flags;
                            state   <= S_DONE;
                        end else begin
                            mcand <= sig_a;
                            mq    <= BW'(sig_b);
                            qm1   <= 1'b0;
                            acc   <= '0;
                            cnt   <= CW'(N - 1);
                            e_reg <= e_sum;
                            state <= S_MUL;
                        end
                    end
                end
                S_MUL: begin
                    acc <= AW'(sum >>> 2);
                    mq  <= mq >> 2;
                    qm1 <= mq[1];
                    if (cnt == '0) state <= S_RND;
                    else           cnt   <= cnt - 1'b1;
                end
                S_RND: begin
                    if (e_r >= E_MAX) begin
                        res_r   <= {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                        flags_r <= 4'b0101;
                    end else if (e_r <= E_ZRO) begin
                        res_r   <= {sign_r, {(W-1){1'b0}}};
                        flags_r <= 4'b0011;
                    end else begin
                        res_r   <= {sign_r, e_r[EXP_W-1:0], frac_r};
                        flags_r <= {3'b000, guard | sticky};
                    end
                    state <= S_DONE;
                end
                S_DONE: begin
                    if (!out_valid_r) begin
                        out_valid_r <= 1'b1;
                    end else if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready   = (state == S_IDLE);
    assign bus.out_valid  = out_valid_r;
    assign bus.out_result = res_r;
    assign bus.out_flags  = flags_r;
endmodule

// File: tb/tb_fp_mul_seq.sv
// Self-checking bench for fp_mul_seq (half-precision configuration).
module tb_fp_mul_seq;
    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    fp_mul_seq_if #(.EXP_W(5), .MAN_W(10)) bus();

    fp_mul_seq #(.EXP_W(5), .MAN_W(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Exact reference: product = ma*mb*2^(ea+eb-2*bias-2*MAN_W), rounded by integer division.
    // Returns {special, flags[3:0], result[15:0]}.
    function automatic logic [20:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
        int ea, eb, fa, fb, ma, mb, sgn, k, e2, be, sh;
        longint m, q, r, half;
        bit nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
        ea = int'(a[14:10]); fa = int'(a[9:0]);
        eb = int'(b[14:10]); fb = int'(b[9:0]);
        sgn = int'(a[15] ^ b[15]);
        nan_a  = (ea == 31) && (fa != 0);  nan_b  = (eb == 31) && (fb != 0);
        inf_a  = (ea == 31) && (fa == 0);  inf_b  = (eb == 31) && (fb == 0);
        zero_a = (ea == 0) && (fa == 0);   zero_b = (eb == 0) && (fb == 0);
        if (nan_a || nan_b || (inf_a && zero_b) || (inf_b && zero_a))
            return {1'b1, 4'b1000, 16'h7E00};
        if (inf_a || inf_b)
            return {1'b1, 4'b0000, 1'(sgn), 15'h7C00};
        if (zero_a || zero_b)
            return {1'b1, 4'b0000, 1'(sgn), 15'h0000};
        ma = (ea == 0) ? fa : fa + 1024;
        mb = (eb == 0) ? fb : fb + 1024;
        if (ea == 0) ea = 1;
        if (eb == 0) eb = 1;
        m  = longint'(ma) * longint'(mb);
        e2 = ea + eb - 30 - 20;
        k  = 0;
        while ((m >> (k + 1)) != 0) k++;
        be = k + e2 + 15;
        if (k > 10) begin
            sh   = k - 10;
            q    = m >> sh;
            r    = m - (q << sh);
            half = longint'(1) << (sh - 1);
            if (r > half || (r == half && (q % 2) == 1)) q++;
        end else begin
            q = m << (10 - k);
            r = 0;
        end
        if (q == 2048) begin
            q = 1024;
            be++;
        end
        if (be >= 31) return {1'b0, 4'b0101, 1'(sgn), 15'h7C00};
        if (be <= 0)  return {1'b0, 4'b0011, 1'(sgn), 15'h0000};
        return {1'b0, 3'b000, (r != 0), 1'(sgn), 5'(be), 10'(q)};
    endfunction

    function automatic logic [15:0] rnd_op();
        logic [15:0] v;
        v = 16'($urandom);
        case ($urandom_range(0, 3))
            0, 1:    v[14:10] = 5'($urandom_range(8, 22));
            2:       v = v;
            default: v[14:10] = ($urandom_range(0, 1) == 1) ? 5'd0 : 5'($urandom_range(26, 31));
        endcase
        return v;
    endfunction

    // One transaction: accept, latency, result/flags, optional backpressure with a stray pulse.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] er, input logic [3:0] ef, input int lat, input int hold);
        int cyc;
        @(negedge clk);
        bus.in_a = a; bus.in_b = b; bus.in_valid = 1'b1;
        chk({tag, ".in_ready"}, 32'(bus.in_ready), 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.in_a = 16'($urandom); bus.in_b = 16'($urandom);
        chk({tag, ".busy"}, 32'(bus.in_ready), 0);
        cyc = 0;
        while (bus.out_valid !== 1'b1 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, ".latency"}, 32'(cyc), 32'(lat));
        chk({tag, ".result"}, 32'(bus.out_result), 32'(er));
        chk({tag, ".flags"}, 32'(bus.out_flags), 32'(ef));
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = (i == 1);
            @(posedge clk); #1;
            chk({tag, ".hold_valid"}, 32'(bus.out_valid), 1);
            chk({tag, ".hold_result"}, 32'(bus.out_result), 32'(er));
            chk({tag, ".hold_flags"}, 32'(bus.out_flags), 32'(ef));
            chk({tag, ".hold_ready"}, 32'(bus.in_ready), 0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk({tag, ".drained"}, 32'(bus.out_valid), 0);
        chk({tag, ".ready_back"}, 32'(bus.in_ready), 1);
    endtask

    logic [15:0] d_a   [10] = '{16'h4000, 16'h0200, 16'h3C01, 16'h3C01, 16'h7C00,
                                16'hFC00, 16'h8000, 16'h7D55, 16'h7BFF, 16'h0400};
    logic [15:0] d_b   [10] = '{16'h4200, 16'h4400, 16'h3C01, 16'h3E00, 16'h0000,
                                16'h4000, 16'h3C00, 16'h3C00, 16'h4000, 16'h3800};
    logic [15:0] d_res [10] = '{16'h4600, 16'h0800, 16'h3C02, 16'h3E02, 16'h7E00,
                                16'hFC00, 16'h8000, 16'h7E00, 16'h7C00, 16'h0000};
    logic [3:0]  d_flg [10] = '{4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b1000,
                                4'b0000, 4'b0000, 4'b1000, 4'b0101, 4'b0011};
    int          d_lat [10] = '{8, 8, 8, 8, 1, 1, 1, 1, 8, 8};

    initial begin
        logic [20:0] r;
        logic [15:0] a, b;
        int          extra;
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset.in_ready", 32'(bus.in_ready), 1);
        chk("reset.out_valid", 32'(bus.out_valid), 0);
        chk("reset.out_result", 32'(bus.out_result), 0);
        chk("reset.out_flags", 32'(bus.out_flags), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++)
            run_op($sformatf("dir%0d", i), d_a[i], d_b[i], d_res[i], d_flg[i], d_lat[i], 0);

        run_op("backpressure", 16'h4000, 16'h4200, 16'h4600, 4'b0000, 8, 5);

        // reset during the third MUL cycle
        @(negedge clk);
        bus.in_a = 16'h4000; bus.in_b = 16'h4200; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        chk("midrst.out_valid", 32'(bus.out_valid), 0);
        chk("midrst.in_ready", 32'(bus.in_ready), 1);
        chk("midrst.out_result", 32'(bus.out_result), 0);
        chk("midrst.out_flags", 32'(bus.out_flags), 0);
        @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (bus.out_valid !== 1'b0) extra++;
        end
        chk("midrst.no_result", 32'(extra), 0);
        run_op("after_reset", 16'h4000, 16'h4200, 16'h4600, 4'b0000, 8, 0);

        for (int i = 0; i < 150; i++) begin
            a = rnd_op();
            b = rnd_op();
            r = ref_mul(a, b);
            run_op($sformatf("rnd%0d_%04h_%04h", i, a, b), a, b, r[15:0], r[19:16],
                   r[20] ? 1 : 8, $urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
